// File: rtl/tms9918_vdp_if.sv
// CPU bus of the tms9918_vdp: port select, ignored address, write data,
// write strobe, read level and the 16-bit read return.
interface tms9918_vdp_if;
    logic        mode;
    logic [7:0]  addr;
    logic [7:0]  data_in;
    logic [15:0] data_out;
    logic        wr;
    logic        rd;

    modport master (output mode, addr, data_in, wr, rd, input data_out);
    modport slave  (input mode, addr, data_in, wr, rd, output data_out);
endinterface

// File: rtl/tms9918_vdp.sv
// Simplified TMS9918A-style VDP: CPU register/VRAM port, vblank status and
// interrupt, Graphics I rendering pixel-doubled into a 640x480@60 VGA raster
// with RGB332 output. Text mode is built only when TMS9918_TEXT_MODE_EN is
// defined; otherwise reg1[4] is ignored and Graphics I is always used.
module tms9918_vdp #(
    parameter int VRAM_AW = 14,
    parameter int H_OFS   = 64,
    parameter int V_OFS   = 48
) (
    input  logic                clk,
    input  logic                reset,
    tms9918_vdp_if.slave        bus,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [2:0]          vga_red,
    output logic [2:0]          vga_green,
    output logic [1:0]          vga_blue,
    output logic                int_out,
    output logic                debug1,
    output logic                debug2
);
    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_LAST = 10'd524;
    localparam logic [9:0] H0     = 10'(H_OFS);
    localparam logic [9:0] V0     = 10'(V_OFS);
    localparam logic [9:0] F_LINE = V0 + 10'd384;

    logic [7:0]         vram [0:(1<<VRAM_AW)-1];
    logic [7:0]         regs [0:7];
    logic [VRAM_AW-1:0] vaddr, b_addr;
    logic [7:0]         latch, rbuf, vram_qb;
    logic               flag, prefetch, rd_q, rd_edge, status_f, f_set, text;
    logic [15:0]        data_out_r;
    logic [9:0]         h_cnt, v_cnt, iy, txt_ofs, start_m1;
    logic [3:0]         phase, gl_m1, idx;
    logic [5:0]         col;
    logic [7:0]         name_lat, pat_next, clr_next, pat_cur, clr_cur;
    logic               in_img, in_txt, visible, pix_bit;
    logic               unused_bits;

`ifdef TMS9918_TEXT_MODE_EN
    assign text = regs[1][4];
`else
    assign text = 1'b0;
`endif

    assign rd_edge      = bus.rd & ~rd_q;
    assign bus.data_out = data_out_r;
    assign int_out      = status_f & regs[1][5];
    assign f_set        = (h_cnt == H_LAST) && (v_cnt == F_LINE - 10'd1);
    assign unused_bits  = ^{bus.addr, iy[9], iy[0], regs[0], regs[1], regs[2],
                            regs[4], regs[5], regs[6]};

    function automatic logic [7:0] palette(input logic [3:0] c);
        case (c)
            4'd2:    palette = 8'b001_110_01;
            4'd3:    palette = 8'b010_110_01;
            4'd4:    palette = 8'b010_010_11;
            4'd5:    palette = 8'b011_011_11;
            4'd6:    palette = 8'b110_010_01;
            4'd7:    palette = 8'b010_111_11;
            4'd8:    palette = 8'b111_010_01;
            4'd9:    palette = 8'b111_011_01;
            4'd10:   palette = 8'b110_110_01;
            4'd11:   palette = 8'b111_110_10;
            4'd12:   palette = 8'b001_101_00;
            4'd13:   palette = 8'b110_010_10;
            4'd14:   palette = 8'b110_110_11;
            4'd15:   palette = 8'b111_111_11;
            default: palette = 8'b000_000_00;
        endcase
    endfunction

    // CPU port: two-byte register/address writes, VRAM data port, status read.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state always uses <=, so every block samples the
        // pre-edge values and the result does not depend on block ordering.
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            vaddr <= '0; latch <= '0; rbuf <= '0; flag <= 1'b0;
            prefetch <= 1'b0; rd_q <= 1'b0; status_f <= 1'b0;
            data_out_r <= '0; debug1 <= 1'b0;
        end else begin
            debug1   <= bus.wr;
            rd_q     <= bus.rd;
            prefetch <= 1'b0;
            if (prefetch) begin
                rbuf  <= vram[vaddr];
                vaddr <= vaddr + 1'b1;
            end
            if (bus.wr && bus.mode) begin
                if (!flag) begin
                    latch <= bus.data_in;
                    flag  <= 1'b1;
                end else begin
                    flag <= 1'b0;
                    if (bus.data_in[7]) begin
                        regs[bus.data_in[2:0]] <= latch;
                    end else begin
                        vaddr    <= VRAM_AW'({bus.data_in[5:0], latch});
                        prefetch <= ~bus.data_in[6];
                    end
                end
            end else if (bus.wr) begin
                vaddr <= vaddr + 1'b1;
                flag  <= 1'b0;
            end else if (rd_edge && !bus.mode) begin
                data_out_r <= {rbuf, 8'h00};
                rbuf       <= vram[vaddr];
                vaddr      <= vaddr + 1'b1;
                flag       <= 1'b0;
            end else if (rd_edge) begin
                data_out_r <= {status_f, 15'b0};
                flag       <= 1'b0;
            end
            // The frame flag set wins over a status-read clear on the same clock.
            if (f_set)                    status_f <= 1'b1;
            else if (rd_edge && bus.mode) status_f <= 1'b0;
        end
    end

    // VRAM: CPU write port plus a synchronous render read port.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; clearing 16 KB would prevent
        // RAM inference and software initialises VRAM anyway.
        if (bus.wr && !bus.mode) vram[vaddr] <= bus.data_in;
        vram_qb <= vram[b_addr];
    end

    // Raster counters: 800 clocks per line, 525 lines per frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign iy       = v_cnt - V0;
    assign txt_ofs  = {iy[8:4], 5'b0} + {2'b0, iy[8:4], 3'b0} + {4'b0, col};
    assign start_m1 = text ? H0 + 10'd3 : H0 - 10'd17;
    assign gl_m1    = text ? 4'd11 : 4'd15;
    assign in_img   = (h_cnt >= H0) && (h_cnt < H0 + 10'd512) &&
                      (v_cnt >= V0) && (v_cnt < V0 + 10'd384);
    assign in_txt   = (h_cnt >= H0 + 10'd16) && (h_cnt < H0 + 10'd496);
    assign visible  = (h_cnt < 10'd640) && (v_cnt < 10'd480);

    // Render port address: name at phase 0, pattern at 1, colour at 2.
    always_comb begin
        // NOTE: default first so no path leaves b_addr unassigned (no latch).
        b_addr = text ? VRAM_AW'({regs[2][3:0], txt_ofs})
                      : VRAM_AW'({regs[2][3:0], iy[8:4], col[4:0]});
        if (phase == 4'd1)      b_addr = VRAM_AW'({regs[4][2:0], vram_qb, iy[3:1]});
        else if (phase == 4'd2) b_addr = VRAM_AW'({regs[3], 1'b0, name_lat[7:3]});
    end

    // Group sequencer: fetch the next group one group ahead, swap at its end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0; col <= '0; name_lat <= '0;
            pat_next <= '0; clr_next <= '0; pat_cur <= '0; clr_cur <= '0;
        end else begin
            if (h_cnt == start_m1) begin
                phase <= '0;
                col   <= '0;
            end else if (phase == gl_m1) begin
                phase <= '0;
                col   <= col + 6'd1;
            end else begin
                phase <= phase + 4'd1;
            end
            case (phase)
                4'd1:    name_lat <= vram_qb;
                4'd2:    pat_next <= vram_qb;
                4'd3:    clr_next <= vram_qb;
                default: ;
            endcase
            if (phase == gl_m1) begin
                pat_cur <= pat_next;
                clr_cur <= clr_next;
            end
        end
    end

    // Pixel colour index; transparent (0) falls through to the backdrop.
    always_comb begin
        pix_bit = pat_cur[~phase[3:1]];
        idx     = regs[7][3:0];
        if (in_img && regs[1][6] && (!text || in_txt)) begin
            if (text) idx = pix_bit ? regs[7][7:4] : regs[7][3:0];
            else      idx = pix_bit ? clr_cur[7:4] : clr_cur[3:0];
        end
        if (idx == 4'd0) idx = regs[7][3:0];
    end

    // Registered video outputs; syncs share the one-clock pixel latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            debug2    <= 1'b0;
            {vga_red, vga_green, vga_blue} <= '0;
        end else begin
            vga_hsync <= ~((h_cnt >= 10'd656) && (h_cnt < 10'd752));
            vga_vsync <= ~((v_cnt == 10'd490) || (v_cnt == 10'd491));
            debug2    <= in_img;
            {vga_red, vga_green, vga_blue} <= visible ? palette(idx) : 8'h00;
        end
    end
endmodule

// File: tb/tb_tms9918_vdp.sv
// Directed self-checking bench for tms9918_vdp: reset state, register and
// VRAM port, address wrap, raster timing, Graphics I pixels, vblank interrupt.
module tb_tms9918_vdp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic vga_hsync, vga_vsync, int_out, debug1, debug2;
    logic [2:0] vga_red, vga_green;
    logic [1:0] vga_blue;
    int unsigned cyc;
    int checks = 0;
    int failures = 0;
    logic dbg_seen;

    tms9918_vdp_if bus();

    tms9918_vdp dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_red   (vga_red),
        .vga_green (vga_green),
        .vga_blue  (vga_blue),
        .int_out   (int_out),
        .debug1    (debug1),
        .debug2    (debug2)
    );

    // 25 MHz pixel clock.
    always #20 clk = ~clk;

    // Clocks since reset release; equals the raster position of the counters.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Hard stop if anything stalls.
    initial begin
        #(40 * 200000);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic m, input logic [7:0] d);
        bus.mode = m; bus.data_in = d; bus.wr = 1'b1;
        @(negedge clk);
        dbg_seen = debug1;
        bus.wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input logic m, output logic [15:0] q);
        bus.mode = m; bus.rd = 1'b1;
        @(negedge clk);
        q = bus.data_out;
        bus.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic at_pos(input int unsigned line, input int unsigned x);
        int unsigned tgt;
        tgt = line * 800 + x + 1;
        if (cyc > tgt) check("schedule", cyc, tgt);
        while (cyc < tgt) @(negedge clk);
    endtask

    function automatic logic sync_sel(input bit vs);
        return vs ? vga_vsync : vga_hsync;
    endfunction

    task automatic measure(input bit vs, input int bound, output int unsigned fall_at, output int low_len);
        int n;
        n = 0; low_len = 0;
        while (sync_sel(vs) !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        while (sync_sel(vs) !== 1'b0 && n < bound) begin @(negedge clk); n++; end
        fall_at = cyc;
        while (sync_sel(vs) === 1'b0 && n < bound) begin @(negedge clk); n++; low_len++; end
    endtask

    initial begin
        logic [7:0] reg_vals [0:7];
        logic [15:0] q;
        int unsigned f1, f2, c0, exp_c;
        int len1, len2, n;
        reg_vals = '{8'h00, 8'hE2, 8'hF0, 8'h0E, 8'hF9, 8'h86, 8'hF8, 8'hF2};
        bus.mode = 1'b0; bus.addr = 8'h5C; bus.data_in = 8'h00;
        bus.wr = 1'b0; bus.rd = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 16'h0000);
        check("rst_int_out", int_out, 1'b0);
        check("rst_hsync", vga_hsync, 1'b1);
        check("rst_vsync", vga_vsync, 1'b1);
        check("rst_rgb", {vga_red, vga_green, vga_blue}, 8'h00);
        check("rst_debug2", debug2, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cpu_wr(1'b1, reg_vals[i]);
            if (i == 0) check("debug1_pulse", dbg_seen, 1'b1);
            cpu_wr(1'b1, 8'h80 | 8'(i));
        end
        check("debug1_idle", debug1, 1'b0);
        cpu_rd(1'b1, q);
        check("status_idle", q, 16'h0000);

        at_pos(10, 10);  check("border_l10", {vga_red, vga_green, vga_blue}, 8'h39);
        at_pos(10, 639); check("border_x639", {vga_red, vga_green, vga_blue}, 8'h39);
        at_pos(10, 640); check("offscreen_x640", {vga_red, vga_green, vga_blue}, 8'h00);
        at_pos(10, 700); check("offscreen_x700", {vga_red, vga_green, vga_blue}, 8'h00);

        measure(1'b0, 2000, f1, len1);
        measure(1'b0, 2000, f2, len2);
        check("hsync_fall_col", f1 % 800, 657);
        check("hsync_low_len", len1, 96);
        check("hsync_period", f2 - f1, 800);

        cpu_wr(1'b1, 8'h34); cpu_wr(1'b1, 8'h52);
        cpu_wr(1'b0, 8'h5A); cpu_wr(1'b0, 8'hEE);
        cpu_wr(1'b1, 8'h34); cpu_wr(1'b1, 8'h12);
        cpu_rd(1'b0, q); check("vram_rd_1234", q, 16'h5A00);
        cpu_rd(1'b0, q); check("vram_rd_1235", q, 16'hEE00);
        cpu_wr(1'b1, 8'hFF); cpu_wr(1'b1, 8'h7F);
        cpu_wr(1'b0, 8'hAA); cpu_wr(1'b0, 8'hBB);
        cpu_wr(1'b1, 8'hFF); cpu_wr(1'b1, 8'h3F);
        cpu_rd(1'b0, q); check("vram_rd_3fff", q, 16'hAA00);
        cpu_rd(1'b0, q); check("vram_rd_wrap0", q, 16'hBB00);

        cpu_wr(1'b1, 8'h00); cpu_wr(1'b1, 8'h40); cpu_wr(1'b0, 8'h00);
        cpu_wr(1'b1, 8'h00); cpu_wr(1'b1, 8'h48); cpu_wr(1'b0, 8'h70);
        cpu_wr(1'b1, 8'h80); cpu_wr(1'b1, 8'h43); cpu_wr(1'b0, 8'hF1);

        at_pos(47, 100); check("above_img_rgb", {vga_red, vga_green, vga_blue}, 8'h39);
        check("above_img_dbg2", debug2, 1'b0);
        at_pos(48, 100); check("img_top_dbg2", debug2, 1'b1);
        at_pos(49, 63);  check("img_left_rgb", {vga_red, vga_green, vga_blue}, 8'h39);
        check("img_left_dbg2", debug2, 1'b0);
        for (int x = 64; x < 80; x++) begin
            int p;
            p = (x - 64) / 2;
            at_pos(49, x);
            check($sformatf("tile0_x%0d", x), {vga_red, vga_green, vga_blue},
                  (p >= 1 && p <= 3) ? 8'hFF : 8'h00);
            if (x == 64) check("img_in_dbg2", debug2, 1'b1);
        end
        at_pos(49, 575); check("img_right_dbg2", debug2, 1'b1);
        at_pos(49, 576); check("past_img_dbg2", debug2, 1'b0);
        check("past_img_rgb", {vga_red, vga_green, vga_blue}, 8'h39);

        // Skip ahead to the last image line so vblank is reachable quickly.
        c0 = cyc;
        force dut.v_cnt = 10'd431;
        @(negedge clk);
        release dut.v_cnt;
        exp_c = (c0 / 800 + 1) * 800;
        n = 0;
        while (int_out !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("int_rise_cyc", cyc, exp_c);
        cpu_rd(1'b1, q);
        check("status_vblank", q, 16'h8000);
        check("int_cleared", int_out, 1'b0);
        cpu_rd(1'b1, q);
        check("status_after_clr", q, 16'h0000);

        force dut.v_cnt = 10'd489;
        @(negedge clk);
        release dut.v_cnt;
        measure(1'b1, 4000, f1, len1);
        check("vsync_fall_col", f1 % 800, 1);
        check("vsync_low_len", len1, 1600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
